// File: rtl/fp_mul_arbiter.sv
// Round-robin front end sharing one pipelined fpMul among NUM_REQ requesters.
// Ports: req_* operand handshakes in, mul_* to/from fpMul, rsp_* result FIFO out, busy.
module fp_mul_arbiter #(
   parameter  int EXPONENT_WIDTH = 5,
   parameter  int MANTISSA_WIDTH = 10,
   parameter  int NUM_REQ        = 4,
   parameter  int MUL_LATENCY    = 1,
   parameter  int FIFO_DEPTH     = 4,
   localparam int W   = EXPONENT_WIDTH + MANTISSA_WIDTH + 1,
   localparam int IDW = $clog2(NUM_REQ)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [NUM_REQ*W-1:0] req_a,
   input  logic [NUM_REQ*W-1:0] req_b,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic [W-1:0]         mul_a,
   output logic [W-1:0]         mul_b,
   output logic                 mul_valid,
   input  logic [W-1:0]         mul_result,
   output logic                 rsp_valid,
   output logic [IDW-1:0]       rsp_id,
   output logic [W-1:0]         rsp_data,
   input  logic                 rsp_ready,
   output logic                 busy
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int FW = $clog2(MUL_LATENCY + 2);

   logic [IDW-1:0]     ptr;
   logic [IDW-1:0]     grant_id;
   logic [IDW-1:0]     idx;
   logic               grant_any;
   logic               credit;
   logic               transfer;

   logic [MUL_LATENCY:0] tag_vld;
   logic [IDW-1:0]       tag_id [MUL_LATENCY+1];
   logic [FW-1:0]        inflight;

   logic [IDW+W-1:0]   mem [FIFO_DEPTH];
   logic [AW-1:0]      head;
   logic [AW-1:0]      tail;
   logic [CW-1:0]      count;
   logic [IDW+W-1:0]   head_q;
   logic               push;
   logic               pop;

   function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] p);
      return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   // first valid requester at or after ptr, ascending with wrap
   always_comb begin
      grant_any = 1'b0;
      grant_id  = ptr;
      idx       = ptr;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = ptr + IDW'(k);
         if (!grant_any && req_valid[idx]) begin
            grant_any = 1'b1;
            grant_id  = idx;
         end
      end
   end

   always_comb begin
      inflight = '0;
      for (int s = 0; s <= MUL_LATENCY; s++)
         inflight = inflight + FW'(tag_vld[s]);
   end

   // every accepted op owns a slot until it has been popped
   assign credit    = (int'(count) + int'(inflight)) < FIFO_DEPTH;
   assign req_ready = (credit && grant_any) ?
                      (NUM_REQ'(1) << grant_id) : '0;
   assign transfer  = |(req_valid & req_ready);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr       <= '0;
         mul_a     <= '0;
         mul_b     <= '0;
         mul_valid <= 1'b0;
         tag_vld   <= '0;
      end else begin
         mul_valid  <= transfer;
         tag_vld[0] <= transfer;
         for (int s = 1; s <= MUL_LATENCY; s++)
            tag_vld[s] <= tag_vld[s-1];
         if (transfer) begin
            ptr   <= grant_id + IDW'(1);
            mul_a <= req_a[grant_id*W +: W];
            mul_b <= req_b[grant_id*W +: W];
         end
      end
   end

   always_ff @(posedge clk) begin
      tag_id[0] <= grant_id;
      for (int s = 1; s <= MUL_LATENCY; s++)
         tag_id[s] <= tag_id[s-1];
   end

   // the last tag stage lines up with mul_result
   assign push = tag_vld[MUL_LATENCY];
   assign pop  = rsp_valid & rsp_ready;

   always_ff @(posedge clk) begin
      if (push)
         mem[tail] <= {tag_id[MUL_LATENCY], mul_result};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push)
            tail <= wrap_inc(tail);
         if (pop)
            head <= wrap_inc(head);
         count <= count + CW'(push) - CW'(pop);
      end
   end

   assign head_q    = mem[head];
   assign rsp_valid = (count != '0);
   assign rsp_id    = rsp_valid ? head_q[IDW+W-1:W] : '0;
   assign rsp_data  = rsp_valid ? head_q[W-1:0] : '0;
   assign busy      = (inflight != '0) | rsp_valid;

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Randomized bench for fp_mul_arbiter against a transaction-level model.
// Also acts as the attached one-cycle fpMul (truncating half-precision multiply).
module tb_fp_mul_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  req_valid = '0;
   logic [63:0] req_a = '0;
   logic [63:0] req_b = '0;
   logic [3:0]  req_ready;
   logic [15:0] mul_a, mul_b;
   logic        mul_valid;
   logic [15:0] mul_result = '0;
   logic        rsp_valid;
   logic [1:0]  rsp_id;
   logic [15:0] rsp_data;
   logic        rsp_ready = 1'b0;
   logic        busy;

   fp_mul_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
      .req_ready(req_ready),
      .mul_a(mul_a), .mul_b(mul_b), .mul_valid(mul_valid),
      .mul_result(mul_result),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
      .rsp_ready(rsp_ready), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] fmul(input logic [15:0] a, input logic [15:0] b);
      logic [10:0] ma, mb;
      logic [21:0] p;
      logic [9:0]  m;
      int          e;
      ma = {1'b1, a[9:0]};
      mb = {1'b1, b[9:0]};
      p  = ma * mb;
      e  = int'(a[14:10]) + int'(b[14:10]) - 15;
      if (p[21]) begin
         m = p[20:11];
         e = e + 1;
      end else begin
         m = p[19:10];
      end
      return {a[15] ^ b[15], e[4:0], m};
   endfunction

   always @(posedge clk) mul_result <= fmul(mul_a, mul_b);

   typedef struct {
      int          id;
      logic [15:0] d;
      int          rdy;
   } txn_t;

   txn_t        q[$];
   int          ptr_m = 0;
   int          cyc = 0;
   logic        last_acc = 1'b0;
   logic [15:0] last_a, last_b;
   logic [15:0] op_a [4];
   logic [15:0] op_b [4];
   int          total = 0;
   int          bad = 0;

   logic        s_rv;
   logic [1:0]  s_id;
   logic [15:0] s_data;
   logic [3:0]  s_ready;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [15:0] rnd_fp();
      logic [15:0] v;
      v[15]    = 1'($urandom);
      v[14:10] = 5'($urandom_range(22, 8));
      v[9:0]   = 10'($urandom);
      return v;
   endfunction

   task automatic rnd_ops();
      for (int i = 0; i < 4; i++) begin
         op_a[i] = rnd_fp();
         op_b[i] = rnd_fp();
      end
   endtask

   task automatic step(input logic [3:0] v, input logic rr);
      int          g;
      int          ix;
      logic [3:0]  er;
      logic        erv;
      @(negedge clk);
      req_valid = v;
      rsp_ready = rr;
      for (int i = 0; i < 4; i++) begin
         req_a[i*16 +: 16] = op_a[i];
         req_b[i*16 +: 16] = op_b[i];
      end
      #1;
      g = -1;
      for (int k = 0; k < 4; k++) begin
         ix = (ptr_m + k) % 4;
         if (g < 0 && v[ix]) g = ix;
      end
      er = (q.size() < 4 && g >= 0) ? 4'(1 << g) : 4'b0;
      check("req_ready", 32'(req_ready), 32'(er));
      check("mul_valid", 32'(mul_valid), 32'(last_acc));
      if (last_acc) begin
         check("mul_a", 32'(mul_a), 32'(last_a));
         check("mul_b", 32'(mul_b), 32'(last_b));
      end
      erv = (q.size() > 0) && (q[0].rdy <= cyc);
      check("rsp_valid", 32'(rsp_valid), 32'(erv));
      if (erv && rsp_valid) begin
         check("rsp_id", 32'(rsp_id), 32'(q[0].id));
         check("rsp_data", 32'(rsp_data), 32'(q[0].d));
      end
      check("busy", 32'(busy), 32'(q.size() > 0));
      s_rv    = rsp_valid;
      s_id    = rsp_id;
      s_data  = rsp_data;
      s_ready = req_ready;
      if (erv && rr) void'(q.pop_front());
      last_acc = (er != 4'b0);
      if (last_acc) begin
         q.push_back('{g, fmul(op_a[g], op_b[g]), cyc + 3});
         last_a = op_a[g];
         last_b = op_b[g];
         ptr_m  = (g + 1) % 4;
      end
      cyc++;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n     = 1'b0;
      req_valid = '0;
      rsp_ready = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rst_ready", 32'(req_ready), 32'd0);
      check("rst_mvalid", 32'(mul_valid), 32'd0);
      check("rst_rvalid", 32'(rsp_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_mul_a", 32'(mul_a), 32'd0);
      check("rst_mul_b", 32'(mul_b), 32'd0);
      check("rst_rsp_id", 32'(rsp_id), 32'd0);
      check("rst_rsp_data", 32'(rsp_data), 32'd0);
      q.delete();
      ptr_m    = 0;
      last_acc = 1'b0;
      cyc += 2;
   endtask

   initial begin
      int nacc;
      rnd_ops();
      repeat (2) @(negedge clk);
      do_reset();

      // single requester 2: 5 * 3 = 15
      rnd_ops();
      op_a[2] = 16'h4500;
      op_b[2] = 16'h4200;
      step(4'b0100, 1'b1);
      check("acc35", 32'(s_ready), 32'h4);
      step(4'b0000, 1'b1);
      check("lat35_t1", 32'(s_rv), 32'd0);
      step(4'b0000, 1'b1);
      check("lat35_t2", 32'(s_rv), 32'd0);
      step(4'b0000, 1'b1);
      check("lat35_t3", 32'(s_rv), 32'd1);
      check("id35", 32'(s_id), 32'd2);
      check("data35", 32'(s_data), 32'h4B80);
      step(4'b0000, 1'b1);

      // all requesters, drain enabled: strict rotation
      do_reset();
      for (int i = 0; i < 16; i++) begin
         rnd_ops();
         op_a[3] = 16'hD200;
         op_b[3] = 16'hCC40;
         step(4'b1111, 1'b1);
         check("rr36", 32'(s_ready), 32'(1 << (i % 4)));
         if (s_rv && s_id == 2'd3)
            check("data36", 32'(s_data), 32'h6260);
      end

      // back-pressure: FIFO fills, then drains
      do_reset();
      nacc = 0;
      for (int i = 0; i < 7; i++) begin
         rnd_ops();
         step(4'b1111, 1'b0);
         if (s_ready != 4'b0) nacc++;
      end
      check("acc37", 32'(nacc), 32'd4);
      check("busy37", 32'(busy), 32'd1);
      rnd_ops();
      step(4'b1111, 1'b1);
      check("full39", 32'(s_ready), 32'd0);
      rnd_ops();
      step(4'b1111, 1'b1);
      check("resume39", 32'(s_ready != 4'b0), 32'd1);
      for (int i = 0; i < 8; i++) begin
         rnd_ops();
         step(4'b1111, 1'b1);
      end

      // pointer moves past req 1, so req 3 wins
      do_reset();
      rnd_ops();
      step(4'b0010, 1'b1);
      step(4'b0010, 1'b1);
      step(4'b1010, 1'b1);
      check("rr38_a", 32'(s_ready), 32'h8);
      step(4'b1010, 1'b1);
      check("rr38_b", 32'(s_ready), 32'h2);
      repeat (5) step(4'b0000, 1'b1);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         rnd_ops();
         step(4'($urandom), ($urandom_range(3, 0) != 0));
      end
      repeat (10) step(4'b0000, 1'b1);

      // reset with work in flight
      do_reset();
      for (int i = 0; i < 3; i++) begin
         rnd_ops();
         step(4'b1111, 1'b0);
      end
      do_reset();
      for (int i = 0; i < 5; i++) begin
         step(4'b0000, 1'b1);
         check("post_rst", 32'(s_rv), 32'd0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
